// File: rtl/adder_8bit.sv
// Registered ripple-carry adder: WIDTH full-adder cells, one-cycle latency,
// unsigned carry-out and two's-complement overflow flags.
module adder_8bit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   logic [WIDTH-1:0] sum_d, sum_q;
   logic             carry_d, carry_q;
   logic             overflow_d, overflow_q;
   logic             out_valid_d, out_valid_q;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   // Result registers hold on idle cycles; only the valid flag drops.
   always_comb begin
      sum_d       = sum_q;
      carry_d     = carry_q;
      overflow_d  = overflow_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d      = s;
         carry_d    = c[WIDTH];
         overflow_d = c[WIDTH-1] ^ c[WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign sum       = sum_q;
   assign carry     = carry_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Directed-vector bench for adder_8bit with hand-computed results, plus a
// random sweep against an independent sum/overflow model.
module tb_adder_8bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] sum;
   logic       carry;
   logic       overflow;
   logic       out_valid;

   int unsigned n_checks;
   int unsigned n_pass;

   adder_8bit #(
      .WIDTH(8)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Drive operands at the falling edge, then look at outputs 1ns after the capture edge.
   task automatic apply(input logic [7:0] va, input logic [7:0] vb);
      @(negedge clk);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] es, input logic ec,
                             input logic eo, input logic ev);
      check({tag, ".sum"},       {24'd0, sum},       {24'd0, es});
      check({tag, ".carry"},     {31'd0, carry},     {31'd0, ec});
      check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, eo});
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
   endtask

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic [7:0] es;
      logic       ec;
      logic       eo;
   } vec_t;

   vec_t vecs[8];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      vecs[0] = '{8'd100, 8'd120, 8'd220, 1'b0, 1'b1};
      vecs[1] = '{8'd17,  8'd135, 8'd152, 1'b0, 1'b0};
      vecs[2] = '{8'd255, 8'd2,   8'd1,   1'b1, 1'b0};
      vecs[3] = '{8'd255, 8'd255, 8'd254, 1'b1, 1'b0};
      vecs[4] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
      vecs[5] = '{8'd127, 8'd1,   8'd128, 1'b0, 1'b1};
      vecs[6] = '{8'd128, 8'd128, 8'd0,   1'b1, 1'b1};
      vecs[7] = '{8'd255, 8'd1,   8'd0,   1'b1, 1'b0};

      // Reset held with live operands: nothing may be captured.
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 8'($urandom_range(0, 255));
      b        = 8'($urandom_range(0, 255));
      #1;
      expect_out("reset_async", 8'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset_held", 8'd0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;

      // Back-to-back directed vectors; out_valid must never drop.
      foreach (vecs[i]) begin
         apply(vecs[i].va, vecs[i].vb);
         expect_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].eo, 1'b1);
      end

      // Hold: idle cycles keep the last result with out_valid low.
      apply(8'd100, 8'd120);
      expect_out("hold_capture", 8'd220, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      a        = 8'd1;
      b        = 8'd1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         expect_out($sformatf("hold%0d", k), 8'd220, 1'b0, 1'b1, 1'b0);
      end

      // Mid-stream reset: clear without a clock edge, no stale result afterwards.
      apply(8'd200, 8'd100);
      expect_out("pre_reset", 8'd44, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      a = 8'd50;
      b = 8'd60;
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("midreset_async", 8'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      expect_out("midreset_held", 8'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      expect_out("post_release_idle", 8'd0, 1'b0, 1'b0, 1'b0);
      apply(8'd50, 8'd60);
      expect_out("post_release_vec", 8'd110, 1'b0, 1'b0, 1'b1);

      // Random sweep: unsigned sum from integer add, overflow from operand/result signs.
      for (int k = 0; k < 1000; k++) begin
         logic [7:0] ra, rb, rs;
         logic [8:0] full;
         logic       ro;
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         full = {1'b0, ra} + {1'b0, rb};
         rs   = full[7:0];
         ro   = (ra[7] == rb[7]) && (rs[7] != ra[7]);
         apply(ra, rb);
         expect_out($sformatf("rand%0d", k), rs, full[8], ro, 1'b1);
      end

      @(negedge clk);
      in_valid = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion",
               n_checks);
      $fatal(1, "timeout");
   end

endmodule
